// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// Dynamic branch predictor for the 5-stage RV32I pipeline: a direct-mapped
// table of saturating direction counters with a tagged target per entry.
// The IF stage looks up its PC combinationally against the registered table.
// The EXE stage writes resolved branch/jump outcomes back at the clock edge.
// After reset or flush the table is cleared by a sequential walk, one entry
// per cycle. While the walk runs, lookups predict not-taken and updates are
// ignored.
//
// Ports
//   clk              rising-edge clock
//   rst              synchronous reset, active-low
//   flush            restart the clearing walk (statistics are kept)
//   ready            table valid for lookup/update
//   lk_pc            IF-stage PC to predict
//   pred_taken       predicted direction for lk_pc
//   pred_target      predicted next PC (stored target or lk_pc+4)
//   upd_valid        EXE resolved a branch/jal/jalr this cycle
//   upd_pc           PC of the resolved instruction
//   upd_taken        actual direction
//   upd_target       actual taken target
//   upd_is_jump      unconditional jump (jal/jalr)
//   upd_mispredict   pipeline was flushed for this instruction
//   stat_updates     accepted updates (saturating)
//   stat_mispredicts accepted updates flagged as mispredicted (saturating)
// -----------------------------------------------------------------------------
module branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int TAG_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  output logic        ready,
  input  logic [31:0] lk_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_is_jump,
  input  logic        upd_mispredict,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_WEAK  = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [IDX_W-1:0] WALK_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] WALK_LAST = IDX_W'(ENTRIES - 1);

  typedef enum logic {
    INIT,
    READY
  } state_t;

  // Saturating up/down step of a direction counter.
  function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c,
                                                input logic             up);
    if (up) begin
      return (c == CNT_MAX) ? c : c + CNT_ONE;
    end
    return (c == '0) ? c : c - CNT_ONE;
  endfunction

  // Saturating increment of a 32-bit statistic.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v,
                                            input logic        en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] walk_q;
  logic [IDX_W-1:0] walk_d;

  logic [ENTRIES-1:0] valid_q;
  logic [CNT_W-1:0]   cnt_q [ENTRIES];
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             upd_hit;
  logic             upd_en;
  logic             walk_en;

  // Only the index/tag fields of the PCs select table state; the byte
  // offset and bits above the tag are intentionally ignored.
  logic unused_pc;
  assign unused_pc = ^{lk_pc, upd_pc};

  assign lk_idx  = lk_pc[IDX_W+1:2];
  assign lk_tag  = lk_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx = upd_pc[IDX_W+1:2];
  assign upd_tag = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  assign ready = (state_q == READY);

  // Lookup reads registered table state only, so a same-cycle update to the
  // same entry becomes visible on the following cycle.
  assign lk_hit      = ready & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
  assign pred_taken  = lk_hit & cnt_q[lk_idx][CNT_W-1];
  assign pred_target = pred_taken ? tgt_q[lk_idx] : lk_pc + 32'd4;

  // Updates are accepted only in READY and lose to both reset and flush.
  assign upd_hit = valid_q[upd_idx] & (tag_q[upd_idx] == upd_tag);
  assign upd_en  = rst & (state_q == READY) & upd_valid & ~flush;
  assign walk_en = rst & (state_q == INIT);

  always_comb begin
    state_d = state_q;
    walk_d  = walk_q;
    case (state_q)
      INIT: begin
        if (flush) begin
          walk_d = '0;
        end else begin
          walk_d = walk_q + WALK_ONE;
          if (walk_q == WALK_LAST) begin
            state_d = READY;
          end
        end
      end
      READY: begin
        if (flush) begin
          state_d = INIT;
          walk_d  = '0;
        end
      end
      default: begin
        state_d = INIT;
        walk_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= INIT;
      walk_q  <= '0;
    end else begin
      state_q <= state_d;
      walk_q  <= walk_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stat_updates     <= '0;
      stat_mispredicts <= '0;
    end else begin
      stat_updates     <= sat_inc32(stat_updates, upd_en);
      stat_mispredicts <= sat_inc32(stat_mispredicts, upd_en & upd_mispredict);
    end
  end

  // Valid/counter: cleared by the walk, otherwise trained by updates.
  always_ff @(posedge clk) begin
    if (walk_en) begin
      valid_q[walk_q] <= 1'b0;
      cnt_q[walk_q]   <= '0;
    end else if (upd_en) begin
      if (upd_hit) begin
        cnt_q[upd_idx] <= upd_is_jump ? CNT_MAX : sat_step(cnt_q[upd_idx], upd_taken);
      end else if (upd_taken) begin
        // Miss and taken allocates, evicting whatever aliased there.
        valid_q[upd_idx] <= 1'b1;
        cnt_q[upd_idx]   <= upd_is_jump ? CNT_MAX : CNT_WEAK;
      end
    end
  end

  // Tag/target are meaningless while valid=0, so they need no clearing.
  // On a hit the tag already matches, so rewriting it is harmless.
  always_ff @(posedge clk) begin
    if (upd_en && upd_taken) begin
      tag_q[upd_idx] <= upd_tag;
      tgt_q[upd_idx] <= upd_target;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  localparam int ENTRIES = 64;
  localparam int CNT_W   = 2;
  localparam int TAG_W   = 8;
  localparam int IDX_W   = $clog2(ENTRIES);
  localparam int CMAX    = (1 << CNT_W) - 1;
  localparam int CHALF   = 1 << (CNT_W - 1);

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        ready;
  logic [31:0] lk_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_is_jump = 1'b0;
  logic        upd_mispredict = 1'b0;
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;

  always #5 clk = ~clk;

  branch_predictor #(
    .ENTRIES(ENTRIES),
    .CNT_W  (CNT_W),
    .TAG_W  (TAG_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .ready           (ready),
    .lk_pc           (lk_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_is_jump     (upd_is_jump),
    .upd_mispredict  (upd_mispredict),
    .stat_updates    (stat_updates),
    .stat_mispredicts(stat_mispredicts)
  );

  typedef struct {
    logic        rdy;
    logic        pt;
    logic [31:0] ptg;
    logic [31:0] su;
    logic [31:0] sm;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: a plain table of entries plus a count of how far the
  // clearing phase has progressed (-1 once the table is usable).
  bit          m_known = 0;
  int          m_init  = 0;
  bit          m_valid [ENTRIES];
  int          m_tag   [ENTRIES];
  int          m_cnt   [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  logic [31:0] m_su = '0;
  logic [31:0] m_sm = '0;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) & 32'(ENTRIES - 1));
  endfunction

  function automatic int tag_of(input logic [31:0] pc);
    return int'((pc >> (IDX_W + 2)) & 32'((1 << TAG_W) - 1));
  endfunction

  function automatic exp_t model_lookup();
    exp_t e;
    int   i;
    bit   hit;
    i     = idx_of(lk_pc);
    e.rdy = (m_init < 0);
    hit   = e.rdy && m_valid[i] && (m_tag[i] == tag_of(lk_pc));
    e.pt  = hit && (m_cnt[i] >= CHALF);
    e.ptg = e.pt ? m_tgt[i] : lk_pc + 32'd4;
    e.su  = m_su;
    e.sm  = m_sm;
    return e;
  endfunction

  function automatic void model_edge();
    int i;
    int t;
    bit hit;
    if (!rst) begin
      m_known = 1;
      m_init  = 0;
      m_su    = '0;
      m_sm    = '0;
    end else if (m_init >= 0) begin
      if (flush) begin
        m_init = 0;
      end else begin
        m_init++;
        if (m_init == ENTRIES) begin
          m_init = -1;
          for (int k = 0; k < ENTRIES; k++) begin
            m_valid[k] = 0;
            m_cnt[k]   = 0;
          end
        end
      end
    end else if (flush) begin
      m_init = 0;
    end else if (upd_valid) begin
      if (m_su != 32'hFFFF_FFFF) m_su = m_su + 32'd1;
      if (upd_mispredict && m_sm != 32'hFFFF_FFFF) m_sm = m_sm + 32'd1;
      i   = idx_of(upd_pc);
      t   = tag_of(upd_pc);
      hit = m_valid[i] && (m_tag[i] == t);
      if (hit) begin
        if (upd_is_jump)    m_cnt[i] = CMAX;
        else if (upd_taken) m_cnt[i] = (m_cnt[i] < CMAX) ? m_cnt[i] + 1 : CMAX;
        else                m_cnt[i] = (m_cnt[i] > 0) ? m_cnt[i] - 1 : 0;
        if (upd_taken) m_tgt[i] = upd_target;
      end else if (upd_taken) begin
        m_valid[i] = 1;
        m_tag[i]   = t;
        m_cnt[i]   = upd_is_jump ? CMAX : CHALF;
        m_tgt[i]   = upd_target;
      end
    end
  endfunction

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, required %h", name, $time, act, exp);
    end
  endfunction

  // Drive one cycle of inputs, queue the expected response, advance model.
  task automatic drive(input bit r, input bit f, input logic [31:0] lk,
                       input bit uv, input logic [31:0] upc, input bit ut,
                       input logic [31:0] utg, input bit uj, input bit um);
    rst            = r;
    flush          = f;
    lk_pc          = lk;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_taken      = ut;
    upd_target     = utg;
    upd_is_jump    = uj;
    upd_mispredict = um;
    if (m_known) q.push_back(model_lookup());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input logic [31:0] lk);
    drive(1, 0, lk, 0, 32'h0, 0, 32'h0, 0, 0);
  endtask

  task automatic upd(input logic [31:0] pc, input bit t, input logic [31:0] tg,
                     input bit j, input bit m, input logic [31:0] lk);
    drive(1, 0, lk, 1, pc, t, tg, j, m);
  endtask

  function automatic logic [31:0] rand_pc();
    logic [31:0] pc;
    pc = (32'($urandom_range(0, 3)) << (IDX_W + 2)) | (32'($urandom_range(0, 7)) << 2);
    if ($urandom_range(0, 7) == 0) pc = pc | 32'h0010_0000;
    if ($urandom_range(0, 31) == 0) pc = 32'hFFFF_FFFC;
    return pc;
  endfunction

  // Monitor: compares whatever the DUT presents against the queued model.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("ready", 32'(ready), 32'(e.rdy));
        check("pred_taken", 32'(pred_taken), 32'(e.pt));
        check("pred_target", pred_target, e.ptg);
        check("stat_updates", stat_updates, e.su);
        check("stat_mispredicts", stat_mispredicts, e.sm);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and the clearing walk
    drive(0, 0, 32'h100, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 32'h100, 0, 0, 0, 0, 0, 0);
    repeat (ENTRIES + 2) idle(32'h100);

    // Allocation and counter training
    upd(32'h100, 1, 32'h80, 0, 0, 32'h100);
    idle(32'h100);
    upd(32'h100, 0, 32'h0, 0, 0, 32'h100);
    idle(32'h100);
    repeat (3) upd(32'h100, 1, 32'h80, 0, 0, 32'h100);
    idle(32'h100);
    upd(32'h100, 0, 32'h0, 0, 0, 32'h100);
    idle(32'h100);
    upd(32'h300, 0, 32'h0, 0, 0, 32'h300);
    idle(32'h300);

    // Aliasing on index 0
    idle(32'h200);
    upd(32'h200, 1, 32'h40, 0, 0, 32'h200);
    idle(32'h200);
    idle(32'h100);

    // Same-cycle update and lookup: no bypass
    upd(32'h100, 1, 32'h88, 0, 0, 32'h100);
    idle(32'h100);
    upd(32'h104, 1, 32'h500, 1, 1, 32'h104);
    idle(32'h104);
    idle(32'hFFFF_FFFC);

    // Stats survive flush; updates during the walk are ignored
    upd(32'h100, 1, 32'h80, 0, 0, 32'h100);
    upd(32'h100, 1, 32'h80, 0, 1, 32'h100);
    upd(32'h200, 0, 32'h0, 0, 0, 32'h100);
    upd(32'h300, 1, 32'h90, 0, 1, 32'h300);
    upd(32'h104, 1, 32'h70, 1, 0, 32'h104);
    drive(1, 1, 32'h100, 1, 32'h100, 1, 32'h80, 0, 1);
    repeat (ENTRIES + 2) upd(32'h100, 1, 32'h80, 0, 1, 32'h100);

    // Reset in the middle of the walk
    drive(1, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    repeat (10) idle(32'h100);
    drive(0, 1, 32'h100, 1, 32'h100, 1, 32'h80, 0, 1);
    repeat (ENTRIES + 2) idle(32'h100);

    // Randomized traffic
    for (int n = 0; n < 4000; n++) begin
      bit r;
      bit f;
      r = ($urandom_range(0, 999) != 0);
      f = ($urandom_range(0, 399) == 0);
      drive(r, f, rand_pc(), $urandom_range(0, 1) == 1, rand_pc(),
            $urandom_range(0, 2) != 0, $urandom & 32'hFFFF_FFFC,
            $urandom_range(0, 4) == 0, $urandom_range(0, 3) == 0);
    end

    idle(32'h0);
    repeat (3) @(posedge clk);
    check("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
